mux_pipe_nto1: RTL and testbench

Parametrised, pipelined N-to-1 data selector with valid/ready flow control and an auto-scan mode. It generalises the fixed 16:1 32-bit combinational tree to any power-of-4 input count and any data width. Every 4:1 level is registered, so wide selections close timing at full clock rate. In scan mode it streams all inputs out one per beat, serialising feature or weight banks into the classifier datapath.

---
 rtl/mux_pkg.sv | 39 +++
 rtl/mux4to1_reg.sv | 46 ++++
 rtl/mux_pipe_nto1.sv | 127 ++++++++++++
 tb/tb_mux_pipe_nto1.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the pipelined N-to-1 selector.
// The tree geometry helpers are evaluated at elaboration time only.
package mux_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Number of 4:1 levels needed to reduce n inputs to one.
    function automatic int clog4(input int n);
        int lvls;
        int span;
        lvls = 0;
        span = 1;
        while (span < n) begin
            span = span * 4;
            lvls = lvls + 1;
        end
        return lvls;
    endfunction

    // Index of the first node of level lvl when all levels are packed back to back.
    function automatic int level_base(input int n, input int lvl);
        int base;
        int width;
        base  = 0;
        width = n / 4;
        for (int k = 0; k < lvl; k++) begin
            base  = base + width;
            width = width / 4;
        end
        return base;
    endfunction

endpackage

// File: rtl/mux4to1_reg.sv
// One registered 4:1 selection node. Data is chosen by a 2-bit slice of the
// index; tag, valid and last ride along unchanged. Everything holds when en is low.
module mux4to1_reg #(
    parameter int DWIDTH = 32,
    parameter int SELW   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DWIDTH-1:0]   in_data,
    input  logic [1:0]            sel,
    input  logic [SELW-1:0]       in_tag,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic [DWIDTH-1:0]     out_data,
    output logic [SELW-1:0]       out_tag,
    output logic                  out_valid,
    output logic                  out_last
);

    logic [DWIDTH-1:0] pick;

    always_comb begin
        case (sel)
            2'd0:    pick = in_data[0*DWIDTH +: DWIDTH];
            2'd1:    pick = in_data[1*DWIDTH +: DWIDTH];
            2'd2:    pick = in_data[2*DWIDTH +: DWIDTH];
            default: pick = in_data[3*DWIDTH +: DWIDTH];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_tag   <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (en) begin
            out_data  <= pick;
            out_tag   <= in_tag;
            out_valid <= in_valid;
            out_last  <= in_last;
        end
    end

endmodule

// File: rtl/mux_pipe_nto1.sv
// Pipelined N-to-1 selector with valid/ready flow control and an auto-scan mode.
// A tree of registered 4:1 nodes, one level per 2 index bits, all frozen by a global stall.
module mux_pipe_nto1
    import mux_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NUM_IN = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_IN*DWIDTH-1:0]    in_bus,
    input  logic                        mode,
    input  logic [$clog2(NUM_IN)-1:0]   sel,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        start,
    output logic                        busy,
    output logic [DWIDTH-1:0]           out_data,
    output logic [$clog2(NUM_IN)-1:0]   out_sel,
    output logic                        out_valid,
    output logic                        out_last,
    input  logic                        out_ready
);

    localparam int SELW  = $clog2(NUM_IN);
    localparam int L     = clog4(NUM_IN);
    localparam int NODES = (NUM_IN - 1) / 3;
    localparam logic [SELW-1:0] LAST_IDX = SELW'(NUM_IN - 1);

    scan_state_t     state;
    logic [SELW-1:0] cnt;
    logic            stall;
    logic            accept;
    logic            issue_valid;
    logic            issue_last;
    logic [SELW-1:0] issue_idx;

    // All tree nodes, level 0 first, the single root node last.
    logic [DWIDTH-1:0] nd_data  [NODES];
    logic [SELW-1:0]   nd_tag   [NODES];
    logic              nd_valid [NODES];
    logic              nd_last  [NODES];

    assign busy        = (state == SCAN);
    assign stall       = out_valid && !out_ready;
    assign in_ready    = !stall && !busy && (mode == MODE_DIRECT);
    assign accept      = in_valid && in_ready;
    assign issue_valid = busy || accept;
    assign issue_idx   = busy ? cnt : sel;
    assign issue_last  = busy && (cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (start && mode == MODE_SCAN) begin
                        state <= SCAN;
                        cnt   <= '0;
                    end
                end
                SCAN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_IDX) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < L; i++) begin : g_lvl
        localparam int N    = NUM_IN >> (2 * (i + 1));
        localparam int BASE = level_base(NUM_IN, i);
        localparam int PREV = level_base(NUM_IN, i - 1);

        for (genvar j = 0; j < N; j++) begin : g_node
            logic [4*DWIDTH-1:0] d;
            logic [SELW-1:0]     t;
            logic                v;
            logic                la;

            if (i == 0) begin : g_src
                assign d  = in_bus[j*4*DWIDTH +: 4*DWIDTH];
                assign t  = issue_idx;
                assign v  = issue_valid;
                assign la = issue_last;
            end else begin : g_src
                localparam int C = PREV + 4 * j;
                // Sibling nodes carry identical control; only the first child's copy is forwarded.
                logic unused_sib;
                assign d  = {nd_data[C+3], nd_data[C+2], nd_data[C+1], nd_data[C]};
                assign t  = nd_tag[C];
                assign v  = nd_valid[C];
                assign la = nd_last[C];
                assign unused_sib = ^{nd_tag[C+1], nd_tag[C+2], nd_tag[C+3],
                                      nd_valid[C+1], nd_valid[C+2], nd_valid[C+3],
                                      nd_last[C+1], nd_last[C+2], nd_last[C+3]};
            end

            mux4to1_reg #(
                .DWIDTH (DWIDTH),
                .SELW   (SELW)
            ) u_node (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (!stall),
                .in_data   (d),
                .sel       (t[2*i+1 -: 2]),
                .in_tag    (t),
                .in_valid  (v),
                .in_last   (la),
                .out_data  (nd_data[BASE+j]),
                .out_tag   (nd_tag[BASE+j]),
                .out_valid (nd_valid[BASE+j]),
                .out_last  (nd_last[BASE+j])
            );
        end
    end

    assign out_data  = nd_data[NODES-1];
    assign out_sel   = nd_tag[NODES-1];
    assign out_valid = nd_valid[NODES-1];
    assign out_last  = nd_last[NODES-1];

endmodule

// File: tb/tb_mux_pipe_nto1.sv
// Bench for mux_pipe_nto1: 16x32 main instance, plus 64x8 and 4x32 instances
// for the alternate tree depths. Expected beats come from a queue-based model.
module tb_mux_pipe_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance: NUM_IN=16, DWIDTH=32
    logic [16*32-1:0] in_bus;
    logic             mode, in_valid, start, out_ready;
    logic [3:0]       sel;
    wire              in_ready, busy, out_valid, out_last;
    wire  [31:0]      out_data;
    wire  [3:0]       out_sel;

    // Instance B: NUM_IN=64, DWIDTH=8
    logic [64*8-1:0]  bus_b;
    logic             mode_b, in_valid_b, start_b, out_ready_b;
    logic [5:0]       sel_b;
    wire              in_ready_b, busy_b, out_valid_b, out_last_b;
    wire  [7:0]       out_data_b;
    wire  [5:0]       out_sel_b;

    // Instance C: NUM_IN=4, DWIDTH=32
    logic [4*32-1:0]  bus_c;
    logic             mode_c, in_valid_c, start_c, out_ready_c;
    logic [1:0]       sel_c;
    wire              in_ready_c, busy_c, out_valid_c, out_last_c;
    wire  [31:0]      out_data_c;
    wire  [1:0]       out_sel_c;

    mux_pipe_nto1 #(.DWIDTH(32), .NUM_IN(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_bus(in_bus), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .start(start), .busy(busy),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_last(out_last), .out_ready(out_ready));

    mux_pipe_nto1 #(.DWIDTH(8), .NUM_IN(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_bus(bus_b), .mode(mode_b), .sel(sel_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .start(start_b), .busy(busy_b),
        .out_data(out_data_b), .out_sel(out_sel_b), .out_valid(out_valid_b),
        .out_last(out_last_b), .out_ready(out_ready_b));

    mux_pipe_nto1 #(.DWIDTH(32), .NUM_IN(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_bus(bus_c), .mode(mode_c), .sel(sel_c),
        .in_valid(in_valid_c), .in_ready(in_ready_c), .start(start_c), .busy(busy_c),
        .out_data(out_data_c), .out_sel(out_sel_c), .out_valid(out_valid_c),
        .out_last(out_last_c), .out_ready(out_ready_c));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
    } beat_t;

    vec_t        vecs[4];
    logic [3:0]  seq[4];
    beat_t       q[$];
    beat_t       b;
    logic [31:0] ref_w[16];
    int          sent, got, hold, beats, found;
    bit          stalled_done, acc, take;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input bit noise);
        int n_beats;
        int busy_cyc;
        int last_n;
        n_beats  = 0;
        busy_cyc = 0;
        last_n   = -1;
        for (int k = 0; k < 16; k++) in_bus[k*32 +: 32] = 32'h100 + k;
        mode  = 1'b1;
        start = 1'b1;
        #1;
        chk("scan_in_ready_mode1", in_ready, 0);
        step();
        start = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (busy) busy_cyc++;
            if (out_valid) begin
                if (n_beats < 16) begin
                    chk("scan_data", out_data, 32'h100 + n_beats);
                    chk("scan_sel", out_sel, n_beats);
                    chk("scan_last", out_last, n_beats == 15);
                end
                if (out_last) last_n = n;
                n_beats++;
            end
            if (noise) begin
                start    = (n == 5 || n == 12);
                in_valid = (n == 3);
                sel      = 4'd9;
            end
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        chk("scan_beat_count", n_beats, 16);
        chk("scan_busy_cycles", busy_cyc, 16);
        chk("scan_last_time", last_n, 17);
        mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd5,  32'hA5A5_0005};
        vecs[1] = '{4'd0,  32'hA5A5_0000};
        vecs[2] = '{4'd15, 32'hA5A5_000F};
        vecs[3] = '{4'd10, 32'hA5A5_000A};
        seq     = '{4'd0, 4'd15, 4'd7, 4'd3};

        rst_n = 1'b1;
        in_bus = '0; mode = 1'b0; sel = '0; in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        bus_b = '0; mode_b = 1'b0; sel_b = '0; in_valid_b = 1'b0; start_b = 1'b0; out_ready_b = 1'b1;
        bus_c = '0; mode_c = 1'b0; sel_c = '0; in_valid_c = 1'b0; start_c = 1'b0; out_ready_c = 1'b1;
        #1 rst_n = 1'b0;
        step();
        step();

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sel", out_sel, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_b_state", {in_ready_b, busy_b, out_valid_b, out_last_b}, 4'b1000);
        chk("rst_c_state", {in_ready_c, busy_c, out_valid_c, out_last_c}, 4'b1000);
        rst_n = 1'b1;
        step();

        // Table-driven single direct requests, latency 2
        for (int k = 0; k < 16; k++) in_bus[k*32 +: 32] = 32'hA5A5_0000 + k;
        for (int e = 0; e < 4; e++) begin
            sel = vecs[e].sel;
            in_valid = 1'b1;
            #1;
            chk("t1_in_ready", in_ready, 1);
            step();
            in_valid = 1'b0;
            chk("t1_lat1_valid", out_valid, 0);
            step();
            chk("t1_valid", out_valid, 1);
            chk("t1_data", out_data, vecs[e].exp);
            chk("t1_sel", out_sel, vecs[e].sel);
            chk("t1_last", out_last, 0);
            step();
            chk("t1_after_valid", out_valid, 0);
        end

        // Back-to-back stream, no backpressure
        for (int c = 0; c < 8; c++) begin
            if (c < 4) begin
                sel = seq[c];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (c >= 1 && c <= 4) begin
                chk("t2_valid", out_valid, 1);
                chk("t2_data", out_data, 32'hA5A5_0000 + seq[c-1]);
                chk("t2_sel", out_sel, seq[c-1]);
            end else begin
                chk("t2_idle_valid", out_valid, 0);
            end
        end

        // Same stream with beat 2 held off for 3 cycles
        sent = 0; got = 0; hold = 0; stalled_done = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            if (!stalled_done && got == 2 && out_valid) begin
                hold = 3;
                stalled_done = 1'b1;
            end
            out_ready = (hold == 0);
            in_valid  = (sent < 4);
            if (sent < 4) sel = seq[sent];
            #1;
            if (hold > 0) begin
                chk("t3_stall_in_ready", in_ready, 0);
                chk("t3_stall_valid", out_valid, 1);
                chk("t3_stall_data", out_data, 32'hA5A5_0007);
                chk("t3_stall_sel", out_sel, 4'd7);
                hold--;
            end
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                if (got < 4) chk("t3_beat", {out_data, out_sel}, {32'hA5A5_0000 + seq[got], seq[got]});
                got++;
            end
            step();
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("t3_beats_received", got, 4);
        chk("t3_stall_seen", stalled_done, 1);
        for (int c = 0; c < 4; c++) begin
            chk("t3_no_duplicate", out_valid, 0);
            step();
        end

        // Scan with ignored start pulses and ignored direct requests
        run_scan(1'b1);
        step();

        // Reset in the middle of a scan, then a fresh scan
        mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 30 && found == 0; n++) begin
            if (out_valid && out_sel == 4'd6) found = 1;
            else step();
        end
        chk("t5_reached_beat6", found, 1);
        chk("t5_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_out_last", out_last, 0);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            step();
            chk("t5_quiet_after_rst", {out_valid, busy}, 2'b00);
        end
        run_scan(1'b0);
        step();

        // Random direct traffic with random backpressure against a FIFO model
        mode = 1'b0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 16; k++) in_bus[k*32 +: 32] = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            chk("rnd_in_ready", in_ready, !(out_valid && !out_ready));
            if (in_valid && in_ready) q.push_back('{in_bus[sel*32 +: 32], sel});
            if (out_valid && out_ready) begin
                chk("rnd_beat_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    b = q.pop_front();
                    chk("rnd_beat", {out_data, out_sel}, {b.data, b.idx});
                end
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid && q.size() != 0) begin
                b = q.pop_front();
                chk("rnd_drain_beat", {out_data, out_sel}, {b.data, b.idx});
            end
            step();
        end
        chk("rnd_drain_empty", q.size(), 0);
        chk("rnd_drain_idle", out_valid, 0);

        // Scan under random backpressure: indices 0..15 in order, last on 15 only
        for (int k = 0; k < 16; k++) begin
            ref_w[k] = $urandom;
            in_bus[k*32 +: 32] = ref_w[k];
        end
        mode = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        beats = 0;
        for (int c = 0; c < 200 && beats < 16; c++) begin
            out_ready = ($urandom_range(0, 1) != 0);
            #1;
            if (out_valid && out_ready) begin
                chk("rscan_beat", {out_data, out_sel, out_last}, {ref_w[beats], 4'(beats), beats == 15});
                beats++;
            end
            step();
        end
        out_ready = 1'b1;
        chk("rscan_beat_count", beats, 16);
        step();
        chk("rscan_idle", {out_valid, busy}, 2'b00);
        mode = 1'b0;

        // 64x8 instance: three levels
        for (int k = 0; k < 64; k++) bus_b[k*8 +: 8] = 8'(k) ^ 8'hC3;
        for (int e = 0; e < 3; e++) begin
            sel_b = (e == 0) ? 6'd63 : (e == 1) ? 6'd0 : 6'd42;
            in_valid_b = 1'b1;
            step();
            in_valid_b = 1'b0;
            chk("b_lat1_valid", out_valid_b, 0);
            step();
            chk("b_lat2_valid", out_valid_b, 0);
            step();
            chk("b_valid", {out_valid_b, out_last_b}, 2'b10);
            chk("b_data", out_data_b, 8'(sel_b) ^ 8'hC3);
            chk("b_sel", out_sel_b, sel_b);
            step();
        end

        // 4x32 instance: single-level scan, latency 1
        for (int k = 0; k < 4; k++) bus_c[k*32 +: 32] = 32'hC0DE_0000 + k;
        mode_c = 1'b1;
        start_c = 1'b1;
        step();
        start_c = 1'b0;
        beats = 0;
        for (int n = 0; n < 10; n++) begin
            if (out_valid_c) begin
                if (beats < 4) begin
                    chk("c_beat", {out_data_c, out_sel_c, out_last_c}, {32'hC0DE_0000 + beats, 2'(beats), beats == 3});
                    chk("c_latency", n, beats + 1);
                end
                beats++;
            end
            step();
        end
        chk("c_beat_count", beats, 4);
        chk("c_busy_done", busy_c, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
